// File: rtl/rv_decode_pkg.sv
// rv_decode_pkg: shared RV32 opcodes, decoded-op enum, immediate selector and decode bundle.
package rv_decode_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [5:0] {
        OP_ILLEGAL, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
        OP_FENCE, OP_ECALL, OP_EBREAK
    } op_e;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_SH, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;

    typedef struct packed {
        op_e         op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        wr_valid;
        logic        illegal;
    } dec_t;

    function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_sel_e s);
        return s == IMM_I  ? {{20{i[31]}}, i[31:20]} :
               s == IMM_SH ? {27'd0, i[24:20]} :
               s == IMM_S  ? {{20{i[31]}}, i[31:25], i[11:7]} :
               s == IMM_B  ? {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0} :
               s == IMM_U  ? {i[31:12], 12'd0} :
               s == IMM_J  ? {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0} : 32'd0;
    endfunction

endpackage

// File: rtl/rv_decode_if.sv
// rv_decode_if: fetch-side and execute-side handshake bundle of the decode stage.
interface rv_decode_if;
    import rv_decode_pkg::*;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    op_e         out_op;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [31:0] out_imm;
    logic        out_wr_valid;
    logic        out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_op, out_rd, out_rs1, out_rs2,
               out_imm, out_wr_valid, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_op, out_rd, out_rs1, out_rs2,
               out_imm, out_wr_valid, out_illegal
    );

endinterface

// File: rtl/rv_decode_comb.sv
// rv_decode_comb: combinational RV32I(+M) instruction decoder with precise illegal detection.
module rv_decode_comb
    import rv_decode_pkg::*;
#(
    parameter bit EN_M = 1'b0
) (
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    op_e        op;
    imm_sel_e   sel;
    logic       wr;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];

    // Every legal opcode ends in 2'b11, so matching the full opcode also rejects compressed encodings.
    always_comb begin
        op = OP_ILLEGAL;
        case (opc)
            OPC_LUI:      op = OP_LUI;
            OPC_AUIPC:    op = OP_AUIPC;
            OPC_JAL:      op = OP_JAL;
            OPC_JALR:     op = f3 == 3'b000 ? OP_JALR : OP_ILLEGAL;
            OPC_BRANCH:
                case (f3)
                    3'b000:  op = OP_BEQ;
                    3'b001:  op = OP_BNE;
                    3'b100:  op = OP_BLT;
                    3'b101:  op = OP_BGE;
                    3'b110:  op = OP_BLTU;
                    3'b111:  op = OP_BGEU;
                    default: op = OP_ILLEGAL;
                endcase
            OPC_LOAD:
                case (f3)
                    3'b000:  op = OP_LB;
                    3'b001:  op = OP_LH;
                    3'b010:  op = OP_LW;
                    3'b100:  op = OP_LBU;
                    3'b101:  op = OP_LHU;
                    default: op = OP_ILLEGAL;
                endcase
            OPC_STORE:
                case (f3)
                    3'b000:  op = OP_SB;
                    3'b001:  op = OP_SH;
                    3'b010:  op = OP_SW;
                    default: op = OP_ILLEGAL;
                endcase
            OPC_OP_IMM:
                case (f3)
                    3'b000:  op = OP_ADDI;
                    3'b010:  op = OP_SLTI;
                    3'b011:  op = OP_SLTIU;
                    3'b100:  op = OP_XORI;
                    3'b110:  op = OP_ORI;
                    3'b111:  op = OP_ANDI;
                    3'b001:  op = f7 == 7'b0000000 ? OP_SLLI : OP_ILLEGAL;
                    default: op = f7 == 7'b0000000 ? OP_SRLI : f7 == 7'b0100000 ? OP_SRAI : OP_ILLEGAL;
                endcase
            OPC_OP:
                if (f7 == 7'b0000000)
                    case (f3)
                        3'b000:  op = OP_ADD;
                        3'b001:  op = OP_SLL;
                        3'b010:  op = OP_SLT;
                        3'b011:  op = OP_SLTU;
                        3'b100:  op = OP_XOR;
                        3'b101:  op = OP_SRL;
                        3'b110:  op = OP_OR;
                        default: op = OP_AND;
                    endcase
                else if (f7 == 7'b0100000)
                    op = f3 == 3'b000 ? OP_SUB : f3 == 3'b101 ? OP_SRA : OP_ILLEGAL;
                else if (EN_M && f7 == 7'b0000001)
                    op = op_e'(6'(OP_MUL) + {3'd0, f3});
            OPC_MISC_MEM: op = f3 == 3'b000 ? OP_FENCE : OP_ILLEGAL;
            OPC_SYSTEM:   op = instr == 32'h0000_0073 ? OP_ECALL :
                               instr == 32'h0010_0073 ? OP_EBREAK : OP_ILLEGAL;
            default:      op = OP_ILLEGAL;
        endcase
    end

    assign sel = op == OP_ILLEGAL                    ? IMM_NONE :
                 opc == OPC_LUI || opc == OPC_AUIPC  ? IMM_U :
                 opc == OPC_JAL                      ? IMM_J :
                 opc == OPC_BRANCH                   ? IMM_B :
                 opc == OPC_STORE                    ? IMM_S :
                 opc == OPC_JALR || opc == OPC_LOAD  ? IMM_I :
                 opc == OPC_OP_IMM                   ? (f3[1:0] == 2'b01 ? IMM_SH : IMM_I) : IMM_NONE;

    assign wr = op != OP_ILLEGAL && (opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL ||
                opc == OPC_JALR || opc == OPC_LOAD || opc == OPC_OP_IMM || opc == OPC_OP);

    assign dec.op       = op;
    assign dec.rd       = instr[11:7];
    assign dec.rs1      = instr[19:15];
    assign dec.rs2      = instr[24:20];
    assign dec.imm      = imm_gen(instr, sel);
    assign dec.wr_valid = wr && instr[11:7] != 5'd0;
    assign dec.illegal  = op == OP_ILLEGAL;

endmodule

// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered, handshaked RV32 decode stage with optional skid buffer,
// flush and saturating decode/illegal event counters.
module rv_decode_stage
    import rv_decode_pkg::*;
#(
    parameter bit EN_M    = 1'b0,
    parameter bit EN_SKID = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    rv_decode_if.slave       bus,
    output logic [CNT_W-1:0] dec_count,
    output logic [CNT_W-1:0] ill_count
);

    dec_t        dec;
    dec_t        out_d;
    dec_t        skid_d;
    logic [31:0] out_pc;
    logic [31:0] skid_pc;
    logic        out_valid;
    logic        skid_valid;
    logic        accept;
    logic        drain;

    rv_decode_comb #(.EN_M(EN_M)) u_comb (
        .instr (bus.in_instr),
        .dec   (dec)
    );

    // With the skid buffer in_ready depends only on the skid register, never on out_ready.
    assign bus.in_ready = EN_SKID ? !skid_valid : !out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready && !flush;
    assign drain        = !out_valid || bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_d      <= '0;
            skid_d     <= '0;
            out_pc     <= '0;
            skid_pc    <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (drain) begin
            out_valid  <= skid_valid || accept;
            skid_valid <= skid_valid && accept;
            if (skid_valid) begin
                out_d  <= skid_d;
                out_pc <= skid_pc;
            end else if (accept) begin
                out_d  <= dec;
                out_pc <= bus.in_pc;
            end
            if (skid_valid && accept) begin
                skid_d  <= dec;
                skid_pc <= bus.in_pc;
            end
        end else if (accept && EN_SKID) begin
            skid_valid <= 1'b1;
            skid_d     <= dec;
            skid_pc    <= bus.in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_count <= '0;
            ill_count <= '0;
        end else if (accept) begin
            dec_count <= dec_count + {{(CNT_W-1){1'b0}}, ~&dec_count};
            ill_count <= ill_count + {{(CNT_W-1){1'b0}}, dec.illegal && ~&ill_count};
        end
    end

    assign bus.out_valid    = out_valid;
    assign bus.out_pc       = out_pc;
    assign bus.out_op       = out_d.op;
    assign bus.out_rd       = out_d.rd;
    assign bus.out_rs1      = out_d.rs1;
    assign bus.out_rs2      = out_d.rs2;
    assign bus.out_imm      = out_d.imm;
    assign bus.out_wr_valid = out_d.wr_valid;
    assign bus.out_illegal  = out_d.illegal;

endmodule
